// File: rtl/subleq_core_if.sv
// RAM-side strobe and address bundle of the SUBLEQ core.
// The shared data bus stays a plain inout port on the core.
interface subleq_core_if;
  logic       ope;
  logic       ctl;
  logic       ena;
  logic [7:0] adr;

  modport master (output ope, output ctl, output ena, output adr);
  modport slave  (input  ope, input  ctl, input  ena, input  adr);
endinterface

// File: rtl/subleq_core.sv
// SUBLEQ sequencer/datapath: mem[B] := mem[B] - mem[A], branch to C if the result is <= 0.
// Sole master of a 256x8 asynchronous RAM; all strobes come straight from flops.
module subleq_core #(
  parameter logic [7:0] START_PC  = 8'h00,
  parameter logic [7:0] HALT_ADDR = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          busy,
  output logic          halted,
  output logic [7:0]    pc,
  subleq_core_if.master bus,
  inout  wire  [7:0]    dat
);

  typedef enum logic [3:0] {
    StIdle, StFaAdr, StFaCap, StFbAdr, StFbCap, StFcAdr, StFcCap, StLaAdr,
    StLaCap, StLbAdr, StLbCap, StWrSet, StWrStb, StWrHld, StBr, StHalted
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [7:0] adr_q, adr_d;
  logic       ope_q, ope_d, ctl_q, ctl_d, ena_q, ena_d, drv_q, drv_d;
  logic [7:0] res;
  logic       take;

  assign res  = op_b_q - op_a_q;
  assign take = res[7] | (res == 8'h00);

  // Sequencing and operand capture; captures happen on the edge that ends each *Cap state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StFaAdr;
      StFaAdr: state_d = StFaCap;
      StFaCap: begin a_d = dat; state_d = StFbAdr; end
      StFbAdr: state_d = StFbCap;
      StFbCap: begin b_d = dat; state_d = StFcAdr; end
      StFcAdr: state_d = StFcCap;
      StFcCap: begin c_d = dat; state_d = StLaAdr; end
      StLaAdr: state_d = StLaCap;
      StLaCap: begin op_a_d = dat; state_d = StLbAdr; end
      StLbAdr: state_d = StLbCap;
      StLbCap: begin op_b_d = dat; state_d = StWrSet; end
      StWrSet: state_d = StWrStb;
      StWrStb: state_d = StWrHld;
      StWrHld: state_d = StBr;
      StBr: begin
        pc_d = take ? c_q : pc_q + 8'd3;
        if (take && (c_q == HALT_ADDR)) state_d = StHalted;
        else if (run)                   state_d = StFaAdr;
        else                            state_d = StIdle;
      end
      StHalted: if (!run) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bus values are decoded from the next state so they leave the flops aligned with the state.
  always_comb begin
    ope_d = 1'b1;
    ctl_d = 1'b1;
    ena_d = 1'b1;
    drv_d = 1'b0;
    adr_d = adr_q;
    unique case (state_d)
      StFaAdr, StFaCap: begin ena_d = 1'b0; ope_d = 1'b0; adr_d = pc_d; end
      StFbAdr, StFbCap: begin ena_d = 1'b0; ope_d = 1'b0; adr_d = pc_d + 8'd1; end
      StFcAdr, StFcCap: begin ena_d = 1'b0; ope_d = 1'b0; adr_d = pc_d + 8'd2; end
      StLaAdr, StLaCap: begin ena_d = 1'b0; ope_d = 1'b0; adr_d = a_d; end
      StLbAdr, StLbCap: begin ena_d = 1'b0; ope_d = 1'b0; adr_d = b_d; end
      StWrSet, StWrHld: begin ena_d = 1'b0; drv_d = 1'b1; adr_d = b_q; end
      StWrStb:          begin ena_d = 1'b0; drv_d = 1'b1; ctl_d = 1'b0; adr_d = b_q; end
      default: ;
    endcase
  end

  // Async reset forces ctl high directly, so an interrupted write never produces a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= START_PC;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= 8'h00;
      op_a_q  <= 8'h00;
      op_b_q  <= 8'h00;
      adr_q   <= 8'h00;
      ope_q   <= 1'b1;
      ctl_q   <= 1'b1;
      ena_q   <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      adr_q   <= adr_d;
      ope_q   <= ope_d;
      ctl_q   <= ctl_d;
      ena_q   <= ena_d;
      drv_q   <= drv_d;
    end
  end

  assign bus.ope = ope_q;
  assign bus.ctl = ctl_q;
  assign bus.ena = ena_q;
  assign bus.adr = adr_q;
  assign dat     = drv_q ? res : {8{1'bz}};

  assign pc     = pc_q;
  assign busy   = !((state_q == StIdle) || (state_q == StHalted));
  assign halted = (state_q == StHalted);

endmodule

// File: tb/tb_subleq_core.sv
// Directed bench for subleq_core with a behavioural async RAM and a write scoreboard.
module tb_subleq_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       busy, halted;
  logic [7:0] pc;
  wire  [7:0] dat;

  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic        load = 1'b0;
  logic [15:0] exp_q [$];
  logic [7:0]  rd_log [$];
  logic        rd_phase = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_wr = 0;

  subleq_core_if bus_if ();

  subleq_core #(.START_PC(8'h00), .HALT_ADDR(8'hFF)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .busy   (busy),
    .halted (halted),
    .pc     (pc),
    .bus    (bus_if),
    .dat    (dat)
  );

  always #5 clk = ~clk;

  // RAM reads drive the bus whenever selected with output enabled.
  assign dat = (!bus_if.ena && !bus_if.ope && bus_if.ctl) ? mem[bus_if.adr] : 8'bz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RAM write port plus scoreboard monitor: every ctl falling edge is a write to check.
  always @(negedge bus_if.ctl or posedge load) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] = img[i];
    end else if (!bus_if.ena) begin
      n_wr++;
      mem[bus_if.adr] = dat;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got adr %0h dat %0h, expected no write", bus_if.adr, dat);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("wr_adr", {24'h0, bus_if.adr}, {24'h0, e[15:8]});
        check("wr_dat", {24'h0, dat}, {24'h0, e[7:0]});
      end
    end
  end

  // Log the address of each two-cycle read access.
  always @(negedge clk) begin
    if (rst_n && !bus_if.ena && !bus_if.ope) begin
      if (!rd_phase) rd_log.push_back(bus_if.adr);
      rd_phase <= !rd_phase;
    end else begin
      rd_phase <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      0:       return {7'b0, busy};
      1:       return {7'b0, halted};
      2:       return {7'b0, bus_if.ctl};
      default: return pc;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input logic [7:0] val);
    int n = 0;
    while (probe(sel) !== val && n < 100) begin
      tick();
      n++;
    end
    check(name, {24'h0, probe(sel)}, {24'h0, val});
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic reset_and_load();
    run   = 1'b0;
    rst_n = 1'b0;
    #2;
    load = 1'b1;
    #1;
    load = 1'b0;
    rd_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic one_instr(input string name);
    run = 1'b1;
    wait_for({name, "_start"}, 0, 8'h1);
    run = 1'b0;
    wait_for({name, "_done"}, 0, 8'h0);
  endtask

  initial begin
    int w0;
    int act;
    logic [7:0] wrap_exp [10];

    // Basic non-taken instruction, reset values and instruction length.
    clear_img();
    img[0] = 8'd5; img[1] = 8'd6; img[2] = 8'd7; img[5] = 8'd3; img[6] = 8'd5;
    run = 1'b0;
    #2;
    load = 1'b1;
    #1;
    load = 1'b0;
    #3;
    check("rst_ope", {31'b0, bus_if.ope}, 1);
    check("rst_ctl", {31'b0, bus_if.ctl}, 1);
    check("rst_ena", {31'b0, bus_if.ena}, 1);
    check("rst_adr", {24'b0, bus_if.adr}, 0);
    check("rst_dat_z", {31'b0, dat === 8'bz}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_halted", {31'b0, halted}, 0);
    check("rst_pc", {24'b0, pc}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.push_back({8'd6, 8'd2});
    exp_q.push_back({8'd0, 8'd0});
    run = 1'b1;
    wait_for("t1_start", 0, 8'h1);
    check("t1_fa_adr", {24'b0, bus_if.adr}, 0);
    repeat (14) tick();
    check("t1_next_fa_busy", {31'b0, busy}, 1);
    check("t1_next_fa_ena", {31'b0, bus_if.ena}, 0);
    check("t1_next_fa_adr", {24'b0, bus_if.adr}, 3);
    check("t1_pc", {24'b0, pc}, 3);
    check("t1_mem6", {24'b0, mem[6]}, 2);
    check("t1_one_write", n_wr, 1);
    run = 1'b0;
    wait_for("t1_idle", 0, 8'h0);
    check("t1_pc2", {24'b0, pc}, 3);
    check("t1_mem0", {24'b0, mem[0]}, 0);
    check("t1_drained", exp_q.size(), 0);

    // Branch on zero.
    clear_img();
    img[0] = 8'd8; img[1] = 8'd8; img[2] = 8'd20; img[8] = 8'd4;
    reset_and_load();
    exp_q.push_back({8'd8, 8'd0});
    one_instr("t2");
    check("t2_pc", {24'b0, pc}, 20);
    check("t2_mem8", {24'b0, mem[8]}, 0);

    // Branch on negative.
    clear_img();
    img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'd30; img[9] = 8'd9; img[10] = 8'd3;
    reset_and_load();
    exp_q.push_back({8'd10, 8'hFA});
    one_instr("t3");
    check("t3_pc", {24'b0, pc}, 30);
    check("t3_mem10", {24'b0, mem[10]}, 8'hFA);

    // Halt on a taken branch to 8'hFF.
    clear_img();
    img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'hFF; img[9] = 8'd1; img[10] = 8'd1;
    reset_and_load();
    exp_q.push_back({8'd10, 8'd0});
    run = 1'b1;
    wait_for("t4_halt", 1, 8'h1);
    check("t4_busy", {31'b0, busy}, 0);
    check("t4_pc", {24'b0, pc}, 8'hFF);
    act = 0;
    repeat (10) begin
      tick();
      if (!bus_if.ena || !bus_if.ope || !bus_if.ctl) act++;
    end
    check("t4_quiet", act, 0);
    check("t4_still_halted", {31'b0, halted}, 1);
    run = 1'b0;
    tick();
    check("t4_left_halt", {31'b0, halted}, 0);
    check("t4_idle_busy", {31'b0, busy}, 0);
    check("t4_pc_kept", {24'b0, pc}, 8'hFF);
    check("t4_drained", exp_q.size(), 0);

    // Address wrap: jump to FE, then a non-taken instruction at FE,FF,00.
    clear_img();
    img[0] = 8'd9; img[1] = 8'd9; img[2] = 8'hFE;
    img[8'hFE] = 8'd20; img[8'hFF] = 8'd21; img[20] = 8'd1; img[21] = 8'd5;
    reset_and_load();
    exp_q.push_back({8'd9, 8'd0});
    exp_q.push_back({8'd21, 8'd4});
    run = 1'b1;
    wait_for("t5_at_fe", 3, 8'hFE);
    run = 1'b0;
    wait_for("t5_idle", 0, 8'h0);
    check("t5_pc", {24'b0, pc}, 8'h01);
    check("t5_mem21", {24'b0, mem[21]}, 4);
    wrap_exp = '{8'h00, 8'h01, 8'h02, 8'h09, 8'h09, 8'hFE, 8'hFF, 8'h00, 8'd20, 8'd21};
    check("t5_nreads", rd_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < rd_log.size()) check($sformatf("t5_rd%0d", i), {24'b0, rd_log[i]}, {24'b0, wrap_exp[i]});
    end
    check("t5_drained", exp_q.size(), 0);

    // Async reset while the write strobe is low; opA = 0 keeps the target byte's value.
    clear_img();
    img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'd40; img[10] = 8'd7;
    reset_and_load();
    exp_q.push_back({8'd10, 8'd7});
    run = 1'b1;
    wait_for("t6_strobe", 2, 8'h0);
    w0 = n_wr;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ctl", {31'b0, bus_if.ctl}, 1);
    check("t6_ena", {31'b0, bus_if.ena}, 1);
    check("t6_ope", {31'b0, bus_if.ope}, 1);
    check("t6_dat_z", {31'b0, dat === 8'bz}, 1);
    check("t6_pc", {24'b0, pc}, 0);
    check("t6_busy", {31'b0, busy}, 0);
    repeat (2) tick();
    check("t6_no_extra_wr", n_wr - w0, 0);
    check("t6_mem10", {24'b0, mem[10]}, 7);
    exp_q.push_back({8'd10, 8'd7});
    @(negedge clk);
    rst_n = 1'b1;
    wait_for("t6_restart", 0, 8'h1);
    check("t6_restart_adr", {24'b0, bus_if.adr}, 0);
    run = 1'b0;
    wait_for("t6_idle", 0, 8'h0);
    check("t6_pc_after", {24'b0, pc}, 3);
    check("t6_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end
endmodule
